// File: rtl/ring_mon_pkg.sv
// Shared types and helpers for the ring phase monitor: FSM state encoding,
// index-width calculation and the modulo-N next-phase function.
package ring_mon_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2,
    FAULT   = 2'd3
  } ring_state_t;

  // Width able to hold 0..n-1, never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int next_idx(input int idx, input int n);
    return (idx >= n - 1) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/ring_phase_monitor_onehot_encoder.sv
// Combinational one-hot to binary encoder; legal is high only when exactly
// one input bit is set, and idx is then the position of that bit.
module onehot_encoder
  import ring_mon_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 legal
);

  localparam int IW = $clog2(N);

  logic seen;
  logic multi;

  always_comb begin
    idx   = '0;
    seen  = 1'b0;
    multi = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (onehot[i]) begin
        if (seen) multi = 1'b1;
        seen = 1'b1;
        idx  = IW'(i);
      end
    end
    legal = seen && !multi;
  end

endmodule

// File: rtl/ring_phase_monitor.sv
// Phase tracker for a one-hot ring counter: acquires lock, counts revolutions
// and latches sticky faults. Define RINGMON_STALL_EN to accept repeated phases.
module ring_phase_monitor
  import ring_mon_pkg::*;
#(
  parameter int N          = 4,
  parameter int LOCK_STEPS = 2,
  parameter int REV_W      = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic [N-1:0]         ring_q,
  input  logic                 clear_err,
  output logic [$clog2(N)-1:0] phase_idx,
  output logic                 phase_valid,
  output logic                 locked,
  output logic [REV_W-1:0]     rev_count,
  output logic                 rev_tick,
  output logic                 err_illegal,
  output logic                 err_skip
);

  localparam int IW = $clog2(N);
  localparam int SW = idx_w(LOCK_STEPS + 1);

  ring_state_t   state;
  logic [SW-1:0] step_cnt;
  logic [IW-1:0] enc_idx;
  logic          enc_legal;
  logic [IW-1:0] exp_idx;
  logic          is_next;
  logic          is_hold;

  onehot_encoder #(.N(N)) u_enc (
    .onehot (ring_q),
    .idx    (enc_idx),
    .legal  (enc_legal)
  );

  assign exp_idx = IW'(next_idx(int'(phase_idx), N));
  assign is_next = enc_legal && (enc_idx == exp_idx);

`ifdef RINGMON_STALL_EN
  assign is_hold = enc_legal && (enc_idx == phase_idx);
`else
  assign is_hold = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      step_cnt    <= '0;
      phase_idx   <= '0;
      phase_valid <= 1'b0;
      locked      <= 1'b0;
      rev_count   <= '0;
      rev_tick    <= 1'b0;
      err_illegal <= 1'b0;
      err_skip    <= 1'b0;
    end else begin
      rev_tick <= 1'b0;
      case (state)
        IDLE: begin
          // Non-one-hot samples here are expected after power-up; drop them.
          if (sample_en && enc_legal) begin
            phase_idx   <= enc_idx;
            step_cnt    <= '0;
            state       <= ACQUIRE;
            phase_valid <= 1'b1;
          end
        end
        ACQUIRE: begin
          if (sample_en && !is_hold) begin
            if (is_next) begin
              phase_idx <= enc_idx;
              step_cnt  <= step_cnt + SW'(1);
              if (step_cnt == SW'(LOCK_STEPS - 1)) begin
                state     <= LOCKED;
                locked    <= 1'b1;
                rev_count <= '0;
              end
            end else begin
              state       <= IDLE;
              phase_valid <= 1'b0;
            end
          end
        end
        LOCKED: begin
          if (sample_en && !is_hold) begin
            if (is_next) begin
              phase_idx <= enc_idx;
              // Only an expected advance landing on 0 came from N-1.
              if (enc_idx == '0) begin
                rev_count <= rev_count + REV_W'(1);
                rev_tick  <= 1'b1;
              end
            end else begin
              state       <= FAULT;
              locked      <= 1'b0;
              phase_valid <= 1'b0;
              if (enc_legal) err_skip    <= 1'b1;
              else           err_illegal <= 1'b1;
            end
          end
        end
        FAULT: begin
          if (clear_err) begin
            state       <= IDLE;
            err_illegal <= 1'b0;
            err_skip    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
